// File: rtl/rf8_access_arbiter_if.sv
// Bundles the requester handshakes and register-file access path of the rf8 arbiter.
// Signals: r0_*/r1_* requests and ready, shared rdata/rvalid, sweep_req/busy, rf_* slice controls.
// Optional RF8_ARB_WPROT_EN adds wprot (per-register write protect) and wprot_err (per-requester).
interface rf8_access_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    localparam int NREG = 2**AW;

    logic            r0_valid;
    logic            r0_we;
    logic [AW-1:0]   r0_addr;
    logic [DW-1:0]   r0_wdata;
    logic            r0_ready;

    logic            r1_valid;
    logic            r1_we;
    logic [AW-1:0]   r1_addr;
    logic [DW-1:0]   r1_wdata;
    logic            r1_ready;

    logic [DW-1:0]   rdata;
    logic [1:0]      rvalid;

    logic            sweep_req;
    logic            busy;

    logic [NREG-1:0] rf_en;
    logic [NREG-1:0] rf_clr;
    logic [DW-1:0]   rf_d;
    logic [AW-1:0]   rf_rsel;
    logic [DW-1:0]   rf_q;

`ifdef RF8_ARB_WPROT_EN
    logic [NREG-1:0] wprot;
    logic [1:0]      wprot_err;
`endif

    // Arbiter side.
    modport slave (
`ifdef RF8_ARB_WPROT_EN
        input  wprot,
        output wprot_err,
`endif
        input  r0_valid, r0_we, r0_addr, r0_wdata,
        output r0_ready,
        input  r1_valid, r1_we, r1_addr, r1_wdata,
        output r1_ready,
        output rdata, rvalid,
        input  sweep_req,
        output busy,
        output rf_en, rf_clr, rf_d, rf_rsel,
        input  rf_q
    );

    // Requester / register-file side.
    modport master (
`ifdef RF8_ARB_WPROT_EN
        output wprot,
        input  wprot_err,
`endif
        output r0_valid, r0_we, r0_addr, r0_wdata,
        input  r0_ready,
        output r1_valid, r1_we, r1_addr, r1_wdata,
        input  r1_ready,
        input  rdata, rvalid,
        output sweep_req,
        input  busy,
        input  rf_en, rf_clr, rf_d, rf_rsel,
        output rf_q
    );
endinterface

// File: rtl/rf8_access_arbiter.sv
// Round-robin arbiter for the single access path of an 8x8 register file, plus a clear sweep.
// Latency: accept at N, write enable at N+1, write visible / read data + rvalid at N+2.
// Backpressure: ready only in IDLE; requests and sweeps stall while busy (one access per 2 cycles).
// Ports: clk, clr_n (synchronous active-low), bus (rf8_access_arbiter_if.slave).
// Optional feature macro: RF8_ARB_WPROT_EN (write protect with per-requester error pulse).
module rf8_access_arbiter #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input logic                  clk,
    input logic                  clr_n,
    rf8_access_arbiter_if.slave  bus
);
    localparam int              NREG     = 2**AW;
    localparam logic [NREG-1:0] ONEHOT0  = {{(NREG-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]   IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]   IDX_LAST = {AW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_CLEAR  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;          // id of the most recent grantee
    logic            sweep_pend_q, sweep_pend_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            we_q, we_d;
    logic            gnt_q, gnt_d;            // id of the current grantee
    logic [NREG-1:0] rf_en_q, rf_en_d;
    logic [NREG-1:0] rf_clr_q, rf_clr_d;
    logic [DW-1:0]   rf_d_q, rf_d_d;
    logic [AW-1:0]   rf_rsel_q, rf_rsel_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      rvalid_q, rvalid_d;
`ifdef RF8_ARB_WPROT_EN
    logic            werr_q, werr_d;          // current write was blocked by wprot
    logic [1:0]      wprot_err_q, wprot_err_d;
`endif

    logic            r0_rdy, r1_rdy;
    logic            sel1;
    logic            g_we;
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_wdata;
    logic            g_prot;

    // On a tie, grant whoever was not served last; last_q resets to 1 so req0 wins first.
    assign sel1    = bus.r1_valid && (!bus.r0_valid || !last_q);
    assign g_we    = sel1 ? bus.r1_we    : bus.r0_we;
    assign g_addr  = sel1 ? bus.r1_addr  : bus.r0_addr;
    assign g_wdata = sel1 ? bus.r1_wdata : bus.r0_wdata;
`ifdef RF8_ARB_WPROT_EN
    assign g_prot  = bus.wprot[g_addr];
`else
    assign g_prot  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        sweep_pend_d = sweep_pend_q;
        idx_d        = idx_q;
        we_d         = we_q;
        gnt_d        = gnt_q;
        rf_en_d      = '0;
        rf_clr_d     = '0;
        rf_d_d       = rf_d_q;
        rf_rsel_d    = rf_rsel_q;
        rdata_d      = rdata_q;
        rvalid_d     = '0;
        r0_rdy       = 1'b0;
        r1_rdy       = 1'b0;
`ifdef RF8_ARB_WPROT_EN
        werr_d       = werr_q;
        wprot_err_d  = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.sweep_req || sweep_pend_q) begin
                    // Sweep beats requests; index 0 is cleared in the first CLEAR cycle.
                    state_d      = S_CLEAR;
                    sweep_pend_d = 1'b0;
                    idx_d        = '0;
                    rf_clr_d     = ONEHOT0;
                end else if (bus.r0_valid || bus.r1_valid) begin
                    r0_rdy    = !sel1;
                    r1_rdy    = sel1;
                    gnt_d     = sel1;
                    last_d    = sel1;
                    we_d      = g_we;
                    rf_rsel_d = g_addr;
                    state_d   = S_ACCESS;
                    if (g_we) begin
                        rf_d_d = g_wdata;
                        // Enable is registered so it lands exactly in the ACCESS cycle.
                        if (!g_prot) begin
                            rf_en_d = ONEHOT0 << g_addr;
                        end
                    end
`ifdef RF8_ARB_WPROT_EN
                    werr_d = g_we && g_prot;
`endif
                end
            end

            S_ACCESS: begin
                if (bus.sweep_req) begin
                    sweep_pend_d = 1'b1;
                end
                if (!we_q) begin
                    rdata_d         = bus.rf_q;
                    rvalid_d[gnt_q] = 1'b1;
                end
`ifdef RF8_ARB_WPROT_EN
                if (werr_q) begin
                    wprot_err_d[gnt_q] = 1'b1;
                end
`endif
                state_d = S_IDLE;
            end

            S_CLEAR: begin
                if (bus.sweep_req) begin
                    sweep_pend_d = 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d    = idx_q + IDX_ONE;
                    rf_clr_d = ONEHOT0 << (idx_q + IDX_ONE);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q      <= S_IDLE;
            last_q       <= 1'b1;
            sweep_pend_q <= 1'b0;
            idx_q        <= '0;
            we_q         <= 1'b0;
            gnt_q        <= 1'b0;
            rf_en_q      <= '0;
            rf_clr_q     <= '0;
            rf_d_q       <= '0;
            rf_rsel_q    <= '0;
            rdata_q      <= '0;
            rvalid_q     <= '0;
`ifdef RF8_ARB_WPROT_EN
            werr_q       <= 1'b0;
            wprot_err_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            sweep_pend_q <= sweep_pend_d;
            idx_q        <= idx_d;
            we_q         <= we_d;
            gnt_q        <= gnt_d;
            rf_en_q      <= rf_en_d;
            rf_clr_q     <= rf_clr_d;
            rf_d_q       <= rf_d_d;
            rf_rsel_q    <= rf_rsel_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
`ifdef RF8_ARB_WPROT_EN
            werr_q       <= werr_d;
            wprot_err_q  <= wprot_err_d;
`endif
        end
    end

    assign bus.r0_ready = r0_rdy;
    assign bus.r1_ready = r1_rdy;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.rf_en    = rf_en_q;
    assign bus.rf_clr   = rf_clr_q;
    assign bus.rf_d     = rf_d_q;
    assign bus.rf_rsel  = rf_rsel_q;
    assign bus.rdata    = rdata_q;
    assign bus.rvalid   = rvalid_q;
`ifdef RF8_ARB_WPROT_EN
    assign bus.wprot_err = wprot_err_q;
`endif
endmodule

// File: doc/rf8_access_arbiter.md
Name: rf8_access_arbiter

Overview:
- Shares the single access path of the 8-entry x 8-bit register file (eight enable/clear register slices) between two requesters, req0 and req1.
- Arbitrates round-robin and sequences each access as a write-enable pulse or a read capture.
- Runs a register-by-register clear sweep on request.
- Sits between the requesting datapath blocks and the register file array.

Parameters:
- DW, 8, data width of each register and data bus.
- AW, 3, address width; number of registers NREG = 2**AW.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- clr_n  in  1  synchronous active-low reset.
- r0_valid  in  1  requester 0 access request.
- r0_we  in  1  requester 0: 1 = write, 0 = read.
- r0_addr  in  AW  requester 0 register index.
- r0_wdata  in  DW  requester 0 write data.
- r0_ready  out  1  requester 0 request accepted this cycle.
- r1_valid, r1_we, r1_addr, r1_wdata, r1_ready  same as requester 0, for requester 1.
- rdata  out  DW  read response data, shared.
- rvalid  out  2  one-hot read response strobe per requester.
- sweep_req  in  1  pulse; request a clear of all registers.
- busy  out  1  FSM not in IDLE.
- rf_en  out  NREG  one-hot write enable to register slices.
- rf_clr  out  NREG  one-hot clear to register slices.
- rf_d  out  DW  write data to all slices.
- rf_rsel  out  AW  read mux select.
- rf_q  in  DW  read mux output (combinational from rf_rsel).

Behaviour:
- Reset (clr_n=0 at a clk edge): state=IDLE; rf_en=0; rf_clr=0; rf_d=0; rf_rsel=0; rdata=0; rvalid=0; busy=0; last_grant=1 (req0 wins the first tie); sweep_pend=0; sweep index=0. Reset mid-ACCESS or mid-CLEAR aborts immediately; no further enables are issued.
- FSM states: IDLE, ACCESS, CLEAR.
- IDLE:
  - If sweep_req or sweep_pend: go to CLEAR with index=0, and clear sweep_pend. The sweep has priority over requests; no ready is asserted that cycle.
  - Else if any valid: grant one requester; rX_ready=1 (combinational, IDLE only); latch we/addr/wdata; go to ACCESS.
  - Both valid: grant the requester that is not last_grant. last_grant is updated on each grant.
- ACCESS (exactly 1 cycle):
  - Write: rf_en[addr]=1, rf_d=wdata. The register updates at the end of this cycle.
  - Read: rf_rsel=addr; rdata<=rf_q at the end of the cycle; rvalid[grantee]=1 for the next cycle only.
  - Then go to IDLE.
- Latency and throughput:
  - Accept at cycle N; write visible in the register at N+2; read data with rvalid at N+2.
  - Maximum throughput is one access per 2 cycles.
  - A read issued in the cycle right after a write to the same address returns the new value.
- rf_en and rf_clr are registered outputs and are zero in every cycle except the one stated.
- CLEAR:
  - Each cycle, rf_clr = one-hot(index), then index increments.
  - After index NREG-1 (NREG cycles total), go to IDLE and reset index to 0.
  - Requests stall (ready=0) for the whole sweep.
- sweep_req while busy sets sweep_pend, which is serviced on the next IDLE. Extra sweep_req pulses while pending merge into one.
- busy=1 in ACCESS and CLEAR.
- Requests held valid without ready must stay stable; the arbiter latches only on valid&ready.

Optional Feature:
- Macro: RF8_ARB_WPROT_EN.
- Defined:
  - Adds input wprot[NREG-1:0] and output wprot_err[1:0].
  - A granted write to an address with wprot[addr]=1 still takes the ACCESS cycle, but rf_en stays 0.
  - wprot_err[grantee] pulses for 1 cycle at N+2.
  - The sweep ignores wprot.
- Undefined: no such ports; all writes proceed.

Test Plan:
- Reset then single write: r0 write addr=3 data=0xA5 -> r0_ready at N, rf_en=8'b0000_1000 and rf_d=0xA5 at N+1, no other rf_en bits ever set.
- Read-back: after the write above, r1 read addr=3 -> rvalid=2'b10, rdata=0xA5 at N+2.
- Contention: r0 and r1 valid continuously, both writing -> grants alternate r0, r1, r0, r1. Each grant is 2 cycles apart; the first grant goes to r0 after reset.
- Sweep during access: sweep_req pulsed in an ACCESS cycle with r1 also valid -> the access completes. CLEAR then asserts rf_clr 0x01, 0x02, ..., 0x80 on 8 consecutive cycles before r1_ready. busy=1 throughout.
- Reset mid-sweep: clr_n=0 at CLEAR index 4 -> the next cycle has rf_clr=0, state IDLE, busy=0. A new sweep starts at index 0.
- With RF8_ARB_WPROT_EN: wprot=8'h01, r0 write addr=0 data=0xFF -> rf_en stays 0, wprot_err=2'b01 at N+2, and a read of addr 0 returns the previous value.
